// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - core-side request ports and byte-wide RAM port of mem_ctrl
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_inst;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_inst, mem_done, mem_rdata,
        output ram_addr, ram_we, ram_dout
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_inst, mem_done, mem_rdata,
        input  ram_addr, ram_we, ram_dout
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM arbiter between instruction fetch and load/store
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input logic        clk,
    input logic        rst,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              owner_mem_q, owner_mem_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       acc_q, acc_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic [1:0]        cap_sel;
    logic [31:0]       acc_merged;
    logic [7:0]        wbyte;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // step_q counts edges since accept; the byte landing on ram_din now was issued two edges ago
    assign cap_sel    = step_q[1:0] - 2'd2;
    assign acc_merged = acc_q | (32'(bus.ram_din) << {cap_sel, 3'b000});

    always_comb begin
        case (step_q[1:0])
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        nbytes_d    = nbytes_q;
        base_d      = base_q;
        owner_mem_d = owner_mem_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                // byte 0 goes out on the accepting edge itself
                if (bus.mem_req) begin
                    owner_mem_d = 1'b1;
                    nbytes_d    = size_bytes(bus.mem_size);
                    base_d      = bus.mem_addr;
                    wdata_d     = bus.mem_wdata;
                    acc_d       = '0;
                    step_d      = 3'd1;
                    ram_addr_d  = bus.mem_addr;
                    ram_we_d    = bus.mem_we;
                    ram_dout_d  = bus.mem_wdata[7:0];
                    state_d     = bus.mem_we ? WRITE : READ;
                end else if (bus.if_req && !bus.if_flush) begin
                    owner_mem_d = 1'b0;
                    nbytes_d    = 3'd4;
                    base_d      = bus.if_addr;
                    acc_d       = '0;
                    step_d      = 3'd1;
                    ram_addr_d  = bus.if_addr;
                    state_d     = READ;
                end
            end

            READ: begin
                if (!owner_mem_q && bus.if_flush) begin
                    state_d = IDLE;
                end else begin
                    if (step_q < nbytes_q) begin
                        ram_addr_d = base_q + ADDR_W'(step_q);
                    end
                    if (step_q >= 3'd2) begin
                        acc_d = acc_merged;
                    end
                    if (step_q == nbytes_q + 3'd1) begin
                        state_d = DONE;
                        if (owner_mem_q) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = acc_merged;
                        end else begin
                            if_done_d = 1'b1;
                            if_inst_d = acc_merged;
                        end
                    end
                    step_d = step_q + 3'd1;
                end
            end

            WRITE: begin
                if (step_q == nbytes_q) begin
                    mem_done_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    ram_addr_d = base_q + ADDR_W'(step_q);
                    ram_we_d   = 1'b1;
                    ram_dout_d = wbyte;
                    step_d     = step_q + 3'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            nbytes_q    <= '0;
            base_q      <= '0;
            owner_mem_q <= 1'b0;
            wdata_q     <= '0;
            acc_q       <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            nbytes_q    <= nbytes_d;
            base_q      <= base_d;
            owner_mem_q <= owner_mem_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.mem_rdata = mem_rdata_q;
endmodule
